// File: rtl/nes_rom_loader.sv
// iNES ROM loader: parses the header from the ROM-load byte stream and writes PRG/CHR bytes to SDRAM.
// Optional NES 2.0 extended mapper/size fields are enabled by defining NES2_EN.
module nes_rom_loader #(
  parameter int                ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] PRG_BASE   = 22'h000000,
  parameter logic [ADDR_W-1:0] CHR_BASE   = 22'h200000,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [11:0]       mapper,
  output logic [11:0]       prg_size,
  output logic [11:0]       chr_size,
  output logic              mirroring,
  output logic              battery,
  output logic              loader_busy,
  output logic              loader_done,
  output logic              loader_fail
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DW    = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    PTR_ZERO = {(PTR_W+1){1'b0}};

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_TRAIN, S_PRG, S_CHR, S_DONE, S_FAIL
  } state_t;

  state_t            r_state;
  logic              r_valid_d, r_loading_d;
  logic [3:0]        r_hdr_cnt;
  logic [25:0]       r_remain;
  logic [ADDR_W-1:0] r_offset;
  logic [11:0]       r_mapper, r_prg_size, r_chr_size;
  logic              r_mirroring, r_battery, r_trainer;
  logic              r_busy, r_done, r_fail;
`ifdef NES2_EN
  logic              r_nes2;
`endif

  logic [DW-1:0]     r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;

  logic              w_byte, w_start, w_end;
  logic              w_empty, w_full, w_push_req, w_pop, w_overflow, w_push, w_flush;
  logic [ADDR_W-1:0] w_push_addr;
  logic [DW-1:0]     w_head;
  logic [7:0]        w_magic;

  assign w_byte      = rom_do_valid & ~r_valid_d & rom_loading;
  assign w_start     = rom_loading & ~r_loading_d;
  assign w_end       = ~rom_loading & r_loading_d;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push_req  = w_byte & ~w_start & ((r_state == S_PRG) || (r_state == S_CHR));
  assign w_pop       = ~w_empty & ~r_mem_req & (r_state != S_FAIL) & ~w_start;
  assign w_overflow  = w_push_req & w_full & ~w_pop;
  assign w_push      = w_push_req & ~w_overflow;
  // In FAIL the queue is only discarded once the in-flight write has been acknowledged.
  assign w_flush     = w_start | ((r_state == S_FAIL) & ~r_mem_req);
  assign w_push_addr = ((r_state == S_CHR) ? CHR_BASE : PRG_BASE) + r_offset;
  assign w_head      = r_fifo[r_rd_ptr[PTR_W-1:0]];

  // Expected iNES signature byte for header positions 0-3.
  always_comb begin
    w_magic = 8'h00;
    case (r_hdr_cnt[1:0])
      2'd0:    w_magic = 8'h4E;
      2'd1:    w_magic = 8'h45;
      2'd2:    w_magic = 8'h53;
      2'd3:    w_magic = 8'h1A;
      default: w_magic = 8'h00;
    endcase
  end

  // Byte FIFO between the parser and the memory port.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr[PTR_W-1:0]] <= {w_push_addr, rom_do};
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Memory write port: request held with stable addr/data until the ack pulse.
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_mem_req   <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= 8'h00;
    end else if (r_mem_req && mem_ack) begin
      r_mem_req <= 1'b0;
    end else if (w_pop) begin
      r_mem_req                 <= 1'b1;
      {r_mem_addr, r_mem_wdata} <= w_head;
    end
  end

  // Load sequencer: header parse, trainer skip, PRG/CHR streaming and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_valid_d   <= 1'b0;
      r_loading_d <= 1'b0;
      r_hdr_cnt   <= 4'd0;
      r_remain    <= 26'd0;
      r_offset    <= {ADDR_W{1'b0}};
      r_mapper    <= 12'd0;
      r_prg_size  <= 12'd0;
      r_chr_size  <= 12'd0;
      r_mirroring <= 1'b0;
      r_battery   <= 1'b0;
      r_trainer   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
`ifdef NES2_EN
      r_nes2      <= 1'b0;
`endif
    end else begin
      r_valid_d   <= rom_do_valid;
      r_loading_d <= rom_loading;
      if (r_state == S_DONE && w_empty && !r_mem_req) begin
        r_done <= 1'b1;
      end
      if (w_start) begin
        r_state     <= S_HEADER;
        r_hdr_cnt   <= 4'd0;
        r_remain    <= 26'd0;
        r_offset    <= {ADDR_W{1'b0}};
        r_mapper    <= 12'd0;
        r_prg_size  <= 12'd0;
        r_chr_size  <= 12'd0;
        r_mirroring <= 1'b0;
        r_battery   <= 1'b0;
        r_trainer   <= 1'b0;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_fail      <= 1'b0;
`ifdef NES2_EN
        r_nes2      <= 1'b0;
`endif
      end else if ((w_end && r_busy) || w_overflow) begin
        r_state <= S_FAIL;
        r_fail  <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_byte) begin
        case (r_state)
          S_HEADER: begin
            r_hdr_cnt <= r_hdr_cnt + 4'd1;
            case (r_hdr_cnt)
              4'd0, 4'd1, 4'd2, 4'd3: begin
                if (rom_do != w_magic) begin
                  r_state <= S_FAIL;
                  r_fail  <= 1'b1;
                  r_busy  <= 1'b0;
                end
              end
              4'd4: r_prg_size[7:0] <= rom_do;
              4'd5: r_chr_size[7:0] <= rom_do;
              4'd6: begin
                r_mirroring   <= rom_do[0];
                r_battery     <= rom_do[1];
                r_trainer     <= rom_do[2];
                r_mapper[3:0] <= rom_do[7:4];
              end
              4'd7: begin
                r_mapper[7:4] <= rom_do[7:4];
`ifdef NES2_EN
                r_nes2        <= (rom_do[3:2] == 2'b10);
`endif
              end
`ifdef NES2_EN
              4'd8: begin
                if (r_nes2) begin
                  r_mapper[11:8] <= rom_do[3:0];
                end
              end
              4'd9: begin
                if (r_nes2 && ((rom_do[3:0] == 4'hF) || (rom_do[7:4] == 4'hF))) begin
                  r_state <= S_FAIL;
                  r_fail  <= 1'b1;
                  r_busy  <= 1'b0;
                end else if (r_nes2) begin
                  r_prg_size[11:8] <= rom_do[3:0];
                  r_chr_size[11:8] <= rom_do[7:4];
                end
              end
`endif
              4'd15: begin
                if (r_prg_size == 12'd0) begin
                  r_state <= S_FAIL;
                  r_fail  <= 1'b1;
                  r_busy  <= 1'b0;
                end else if (r_trainer) begin
                  r_state  <= S_TRAIN;
                  r_remain <= 26'd512;
                end else begin
                  r_state  <= S_PRG;
                  r_remain <= {r_prg_size, 14'd0};
                end
              end
              default: ;
            endcase
          end
          S_TRAIN: begin
            if (r_remain == 26'd1) begin
              r_state  <= S_PRG;
              r_remain <= {r_prg_size, 14'd0};
            end else begin
              r_remain <= r_remain - 26'd1;
            end
          end
          S_PRG: begin
            r_offset <= r_offset + ADDR_ONE;
            if (r_remain == 26'd1 && r_chr_size != 12'd0) begin
              r_state  <= S_CHR;
              r_remain <= {1'b0, r_chr_size, 13'd0};
              r_offset <= {ADDR_W{1'b0}};
            end else if (r_remain == 26'd1) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end else begin
              r_remain <= r_remain - 26'd1;
            end
          end
          S_CHR: begin
            r_offset <= r_offset + ADDR_ONE;
            if (r_remain == 26'd1) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end else begin
              r_remain <= r_remain - 26'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_req     = r_mem_req;
  assign mapper      = r_mapper;
  assign prg_size    = r_prg_size;
  assign chr_size    = r_chr_size;
  assign mirroring   = r_mirroring;
  assign battery     = r_battery;
  assign loader_busy = r_busy;
  assign loader_done = r_done;
  assign loader_fail = r_fail;

endmodule

// File: tb/tb_nes_rom_loader.sv
// Directed self-checking bench for nes_rom_loader with a 1-cycle-ack SDRAM responder and write scoreboard.
module tb_nes_rom_loader;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rom_loading = 1'b0;
  logic [7:0]        rom_do = 8'h00;
  logic              rom_do_valid = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_req;
  logic              mem_ack = 1'b0;
  logic [11:0]       mapper, prg_size, chr_size;
  logic              mirroring, battery, loader_busy, loader_done, loader_fail;

  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   wr_err = 0;
  logic stall  = 1'b0;
  logic [29:0] exp_q [$];
  logic [7:0]  d;

  localparam logic [127:0] HDR_BAD   = {8'h4E, 8'h46, 8'h53, 8'h1A, 8'h02, 8'h01, 8'h01, 8'h00, 64'h0};
  localparam logic [127:0] HDR_PRG0  = {8'h4E, 8'h45, 8'h53, 8'h1A, 8'h00, 8'h01, 8'h00, 8'h00, 64'h0};
  localparam logic [127:0] HDR_NES2  = {8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h00, 8'h00, 8'h08,
                                        8'h01, 56'h0};
  localparam logic [127:0] HDR_P1C0  = {8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h00, 8'h00, 8'h00, 64'h0};
  localparam logic [127:0] HDR_P1C1  = {8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h01, 8'h01, 8'h00, 64'h0};
  localparam logic [127:0] HDR_MAIN  = {8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h01, 8'h15, 8'h00, 64'h0};

  always #5 clk = ~clk;

  nes_rom_loader dut (
    .clk          (clk),
    .reset        (reset),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mapper       (mapper),
    .prg_size     (prg_size),
    .chr_size     (chr_size),
    .mirroring    (mirroring),
    .battery      (battery),
    .loader_busy  (loader_busy),
    .loader_done  (loader_done),
    .loader_fail  (loader_fail)
  );

  // SDRAM model: acks each request one cycle after it is seen, scoring addr/data against exp_q.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && !stall) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        wr_err++;
      end else begin
        if ({mem_addr, mem_wdata} !== exp_q[0]) wr_err++;
        void'(exp_q.pop_front());
      end
      mem_ack = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge. Byte is captured on the next posedge.
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    rom_do       = b;
    rom_do_valid = 1'b1;
    repeat (hi) @(negedge clk);
    rom_do_valid = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [127:0] h, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(h[127-8*i -: 8], 2, 1);
  endtask

  task automatic start_load();
    rom_loading = 1'b0;
    @(negedge clk);
    rom_loading = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_busy", loader_busy, 1'b0);
    check("rst_done", loader_done, 1'b0);
    check("rst_fail", loader_fail, 1'b0);
    check("rst_mapper", mapper, 12'h000);
    check("rst_prg", prg_size, 12'h000);
    reset = 1'b0;
    @(negedge clk);

    // Bad signature at byte 1
    start_load();
    check("hdr_busy", loader_busy, 1'b1);
    send_hdr(HDR_BAD, 0, 0);
    check("magic_ok_b0", loader_fail, 1'b0);
    send_hdr(HDR_BAD, 1, 1);
    check("magic_fail_b1", loader_fail, 1'b1);
    send_hdr(HDR_BAD, 2, 15);
    repeat (4) @(negedge clk);
    check("magic_no_req", wr_cnt, 0);
    check("magic_not_done", loader_done, 1'b0);
    check("magic_not_busy", loader_busy, 1'b0);

    // prg_size == 0 fails only after byte 15
    start_load();
    check("restart_clr_fail", loader_fail, 1'b0);
    send_hdr(HDR_PRG0, 0, 14);
    check("prg0_b14", loader_fail, 1'b0);
    send_hdr(HDR_PRG0, 15, 15);
    check("prg0_b15", loader_fail, 1'b1);

    // NES 2.0 header: mapper[11:8] only honoured with NES2_EN
    start_load();
    send_hdr(HDR_NES2, 0, 15);
`ifdef NES2_EN
    check("nes2_mapper", mapper, 12'h100);
`else
    check("nes2_mapper", mapper, 12'h000);
`endif
    check("nes2_prg", prg_size, 12'h001);
    check("nes2_busy", loader_busy, 1'b1);

    // FIFO overflow under a stalled memory port, 4 cycles per byte
    start_load();
    send_hdr(HDR_P1C0, 0, 15);
    wr_cnt = 0;
    exp_q.push_back({22'd0, 8'h11});
    exp_q.push_back({22'd1, 8'h22});
    exp_q.push_back({22'd2, 8'h33});
    send_byte(8'h11, 2, 2);
    send_byte(8'h22, 2, 2);
    send_byte(8'h33, 2, 2);
    repeat (4) @(negedge clk);
    stall = 1'b1;
    exp_q.push_back({22'd3, 8'h44});
    send_byte(8'h44, 2, 2);
    check("stall_req", mem_req, 1'b1);
    check("stall_addr", mem_addr, 22'd3);
    send_byte(8'h55, 2, 2);
    send_byte(8'h66, 2, 2);
    send_byte(8'h77, 2, 2);
    send_byte(8'h88, 2, 2);
    check("full_no_fail", loader_fail, 1'b0);
    send_byte(8'h99, 2, 2);
    check("ovf_fail", loader_fail, 1'b1);
    check("ovf_busy", loader_busy, 1'b0);
    check("ovf_req_held", mem_req, 1'b1);
    check("ovf_addr_stable", mem_addr, 22'd3);
    check("ovf_data_stable", mem_wdata, 8'h44);
    repeat (16) @(negedge clk);
    stall = 1'b0;
    repeat (10) @(negedge clk);
    check("ovf_flush_wr_cnt", wr_cnt, 4);
    check("ovf_exp_empty", exp_q.size(), 0);
    check("ovf_req_idle", mem_req, 1'b0);
    check("ovf_wr_err", wr_err, 0);

    // Reset mid-load drops a pending request immediately
    start_load();
    send_hdr(HDR_P1C0, 0, 15);
    stall = 1'b1;
    send_byte(8'hC3, 2, 1);
    check("midrst_req_before", mem_req, 1'b1);
    reset = 1'b1;
    rom_loading = 1'b0;
    @(negedge clk);
    check("midrst_req", mem_req, 1'b0);
    check("midrst_busy", loader_busy, 1'b0);
    check("midrst_prg", prg_size, 12'h000);
    reset = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);

    // Early end of stream after 1000 PRG bytes
    start_load();
    send_hdr(HDR_P1C1, 0, 15);
    wr_cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      d = 8'(k * 5 + 1);
      exp_q.push_back({22'(k), d});
      send_byte(d, 1, 1);
    end
    repeat (6) @(negedge clk);
    check("early_writes", wr_cnt, 1000);
    check("early_exp_empty", exp_q.size(), 0);
    rom_loading = 1'b0;
    @(negedge clk);
    check("early_fail", loader_fail, 1'b1);
    check("early_not_done", loader_done, 1'b0);

    // Full image after the failure: trainer, 16 KB PRG, 8 KB CHR
    start_load();
    check("reload_fail_clr", loader_fail, 1'b0);
    check("reload_prg_clr", prg_size, 12'h000);
    send_hdr(HDR_MAIN, 0, 15);
    check("main_mapper", mapper, 12'h001);
    check("main_prg", prg_size, 12'h001);
    check("main_chr", chr_size, 12'h001);
    check("main_mirror", mirroring, 1'b1);
    check("main_battery", battery, 1'b0);
    wr_cnt = 0;
    wr_err = 0;
    for (int k = 0; k < 512; k++) send_byte(8'(k ^ 8'hA5), 1, 1);
    repeat (3) @(negedge clk);
    check("trainer_no_writes", wr_cnt, 0);
    for (int k = 0; k < 16384; k++) begin
      d = 8'(k) ^ 8'(k >> 8);
      exp_q.push_back({22'(k), d});
      send_byte(d, 1, 1);
    end
    check("prg_busy", loader_busy, 1'b1);
    for (int k = 0; k < 8192; k++) begin
      d = 8'(k * 3) ^ 8'h5A;
      exp_q.push_back({22'h200000 + 22'(k), d});
      send_byte(d, 1, 1);
    end
    for (int k = 0; k < 3; k++) send_byte(8'hEE, 1, 1);
    repeat (8) @(negedge clk);
    check("main_writes", wr_cnt, 24576);
    check("main_exp_empty", exp_q.size(), 0);
    check("main_wr_err", wr_err, 0);
    check("main_done", loader_done, 1'b1);
    check("main_fail", loader_fail, 1'b0);
    check("main_busy", loader_busy, 1'b0);
    rom_loading = 1'b0;
    repeat (2) @(negedge clk);
    check("done_sticky", loader_done, 1'b1);
    check("done_no_fail", loader_fail, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
